axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 The parameter list SHALL be exactly the following four entries.
- C_M_AXI_DATA_WIDTH, default 32, AXI-Lite data width.
- C_M_AXI_ADDR_WIDTH, default 5, AXI-Lite address width.
- AW = C_M_AXI_ADDR_WIDTH, DW = C_M_AXI_DATA_WIDTH (shorthand used below).
REQ-002 The block SHALL use one clock, M_AXI_ACLK; reset M_AXI_ARESET SHALL be synchronous and active-high.
REQ-003 The port list SHALL be (name, direction, width, meaning):
- M_AXI_ACLK, in, 1, clock.
- M_AXI_ARESET, in, 1, synchronous active-high reset.
- pi_req_valid, in, 1, request valid.
- po_req_ready, out, 1, request accepted when high together with pi_req_valid.
- pi_req_write, in, 1, 1 = write, 0 = read.
- pi_req_addr, in, AW, register byte address.
- pi_req_wdata, in, DW, write data.
- po_rsp_valid, out, 1, response valid.
- pi_rsp_ready, in, 1, response consumed.
- po_rsp_rdata, out, DW, read data (0 for writes).
- po_rsp_resp, out, 2, captured BRESP/RRESP.
- po_rsp_write, out, 1, type of completed request.
- M_AXI_AWADDR, out, AW; M_AXI_AWPROT, out, 3; M_AXI_AWVALID, out, 1; M_AXI_AWREADY, in, 1.
- M_AXI_WDATA, out, DW; M_AXI_WSTRB, out, DW/8; M_AXI_WVALID, out, 1; M_AXI_WREADY, in, 1.
- M_AXI_BRESP, in, 2; M_AXI_BVALID, in, 1; M_AXI_BREADY, out, 1.
- M_AXI_ARADDR, out, AW; M_AXI_ARPROT, out, 3; M_AXI_ARVALID, out, 1; M_AXI_ARREADY, in, 1.
- M_AXI_RDATA, in, DW; M_AXI_RRESP, in, 2; M_AXI_RVALID, in, 1; M_AXI_RREADY, out, 1.

Function
REQ-004 The FSM SHALL have exactly the states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RSP.
REQ-005 po_req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on an edge where pi_req_valid and po_req_ready are both 1.
REQ-006 On accepting a write, the block SHALL register addr/wdata, go to WR_ADDR_DATA, and drive AWVALID=WVALID=1 from the next cycle.
REQ-007 In WR_ADDR_DATA, AWVALID SHALL clear on the edge after AWREADY is sampled 1, WVALID SHALL clear independently on the edge after WREADY is sampled 1, and the block SHALL enter WR_RESP once both handshakes are done (either order, or the same cycle).
REQ-008 AWADDR, WDATA and WSTRB SHALL be stable while their VALID is high, WSTRB SHALL be all ones during VALID, and AWPROT/ARPROT SHALL be 3'b000.
REQ-009 BREADY SHALL be 1 only in WR_RESP; on BVALID&&BREADY the block SHALL capture BRESP, force rdata to 0, set po_rsp_write=1, and go to RSP.
REQ-010 On accepting a read, the block SHALL go to RD_ADDR with ARVALID=1, keep ARADDR stable, clear ARVALID on the edge after ARREADY=1, and then go to RD_DATA.
REQ-011 RREADY SHALL be 1 only in RD_DATA; on RVALID&&RREADY the block SHALL capture RDATA/RRESP, set po_rsp_write=0, and go to RSP.
REQ-012 In RSP, po_rsp_valid SHALL be 1 with rsp fields stable, and the block SHALL return to IDLE on the edge where pi_rsp_ready=1; po_req_ready SHALL be 1 the cycle after that.
REQ-013 The block SHALL have at most one outstanding transaction, and new requests SHALL be stalled (po_req_ready=0) until the response is consumed.
REQ-014 VALID signals SHALL never depend combinationally on the matching READY, and all M_AXI outputs and po_* outputs SHALL be registered.
REQ-015 A non-OKAY BRESP/RRESP SHALL be passed through unchanged, with no retry.
REQ-016 Minimum latency for zero-wait-state slave: accept->AWVALID 1 cycle; write accept->po_rsp_valid 3 cycles; read accept->po_rsp_valid 3 cycles.

Reset
REQ-017 While M_AXI_ARESET=1 at an edge, state SHALL become IDLE, and all VALID/READY outputs, po_rsp_*, the address/data outputs and WSTRB SHALL be 0.
REQ-018 A reset mid-transaction SHALL abandon the transaction with no response, and all VALIDs SHALL be low from the first reset edge.
REQ-019 po_req_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-020 The bench SHALL cover at least the following directed scenarios.
- Write addr 0, data 0xFFFFFFFF, slave AWREADY/WREADY same cycle, BRESP=00 -> one AW and one W beat with WSTRB=0xF; rsp write=1, resp=00, rdata=0.
- Write addr 2, data 0x000007AA, WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID held, single BREADY beat, rsp resp=00.
- Read addr 3, slave RDATA=0x00000001 after 4-cycle RVALID delay -> po_rsp_rdata=0x00000001, write=0; RREADY high exactly in RD_DATA.
- Read returning RRESP=10 -> po_rsp_resp=10 passed through, no retry.
- pi_rsp_ready held low 5 cycles -> rsp fields stable, po_req_ready=0 throughout; back-to-back request accepted the cycle after consumption.
- Reset asserted while AWVALID=1 (AWREADY low) -> AWVALID/WVALID=0 after the edge, no po_rsp_valid, po_req_ready=1 after release.

Source files
------------

// File: rtl/axil_cmd_master.sv
// axil_cmd_master
//   Turns single-beat register requests into AXI4-Lite transactions.
//   Only one transaction is in flight at a time. The response is held on
//   po_rsp_* until the requester consumes it.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESET : clock, synchronous active-high reset
//   pi_req_* / po_req_ready   : request channel (write flag, addr, wdata)
//   po_rsp_* / pi_rsp_ready   : response channel (rdata, resp, write flag)
//   M_AXI_AW*/W*/B*/AR*/R*    : AXI4-Lite master; every output is registered
module axil_cmd_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int AW = C_M_AXI_ADDR_WIDTH,
  parameter int DW = C_M_AXI_DATA_WIDTH
) (
  input  logic            M_AXI_ACLK,
  input  logic            M_AXI_ARESET,
  input  logic            pi_req_valid,
  output logic            po_req_ready,
  input  logic            pi_req_write,
  input  logic [AW-1:0]   pi_req_addr,
  input  logic [DW-1:0]   pi_req_wdata,
  output logic            po_rsp_valid,
  input  logic            pi_rsp_ready,
  output logic [DW-1:0]   po_rsp_rdata,
  output logic [1:0]      po_rsp_resp,
  output logic            po_rsp_write,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [2:0]      M_AXI_AWPROT,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic [AW-1:0]   M_AXI_ARADDR,
  output logic [2:0]      M_AXI_ARPROT,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY
);

  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
  } state_t;

  state_t          r_state, w_next;
  logic            r_req_ready, r_rsp_valid, r_rsp_write;
  logic [DW-1:0]   r_rsp_rdata, r_wdata;
  logic [1:0]      r_rsp_resp;
  logic [AW-1:0]   r_awaddr, r_araddr;
  logic [SW-1:0]   r_wstrb;
  logic            r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic            w_accept, w_aw_done, w_w_done;

  // A channel counts as done once its VALID has already dropped or its
  // handshake completes on this edge; the two channels finish independently.
  assign w_accept  = r_req_ready && pi_req_valid;
  assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) r_state <= IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         if (pi_req_valid) w_next = pi_req_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (w_aw_done && w_w_done) w_next = WR_RESP;
      WR_RESP:      if (M_AXI_BVALID) w_next = RSP;
      RD_ADDR:      if (M_AXI_ARREADY) w_next = RD_DATA;
      RD_DATA:      if (M_AXI_RVALID) w_next = RSP;
      RSP:          if (pi_rsp_ready) w_next = IDLE;
      default:      w_next = IDLE;
    endcase
  end

  // Output registers. The READY/VALID flags that simply track the state are
  // loaded from the next state, so they line up with the state register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_req_ready <= 1'b1;   // state is IDLE after reset, so accept at once
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
    end else begin
      r_req_ready <= (w_next == IDLE);
      r_bready    <= (w_next == WR_RESP);
      r_rready    <= (w_next == RD_DATA);

      if (w_accept && pi_req_write) begin
        r_awaddr  <= pi_req_addr;
        r_wdata   <= pi_req_wdata;
        r_wstrb   <= '1;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end
      if (w_accept && !pi_req_write) begin
        r_araddr  <= pi_req_addr;
        r_arvalid <= 1'b1;
      end

      if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
      if (r_wvalid && M_AXI_WREADY) begin
        r_wvalid <= 1'b0;
        r_wstrb  <= '0;
      end
      if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;

      if (r_state == WR_RESP && M_AXI_BVALID) begin
        r_rsp_valid <= 1'b1;
        r_rsp_write <= 1'b1;
        r_rsp_resp  <= M_AXI_BRESP;
        r_rsp_rdata <= '0;
      end
      if (r_state == RD_DATA && M_AXI_RVALID) begin
        r_rsp_valid <= 1'b1;
        r_rsp_write <= 1'b0;
        r_rsp_resp  <= M_AXI_RRESP;
        r_rsp_rdata <= M_AXI_RDATA;
      end
      if (r_state == RSP && pi_rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  assign po_req_ready  = r_req_ready;
  assign po_rsp_valid  = r_rsp_valid;
  assign po_rsp_write  = r_rsp_write;
  assign po_rsp_rdata  = r_rsp_rdata;
  assign po_rsp_resp   = r_rsp_resp;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] smem [32];   // slave-side register file, written from the bus
  logic [31:0] refm [32];   // reference register file, written from requests

  always #5 clk = ~clk;

  axil_cmd_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .pi_req_valid(req_valid), .po_req_ready(req_ready), .pi_req_write(req_write),
    .pi_req_addr(req_addr), .pi_req_wdata(req_wdata),
    .po_rsp_valid(rsp_valid), .pi_rsp_ready(rsp_ready), .po_rsp_rdata(rsp_rdata),
    .po_rsp_resp(rsp_resp), .po_rsp_write(rsp_write),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; rvalid = 0; rresp = 0; rdata = 0;
    rsp_ready = 0;
  endtask

  // One request from issue to consumption. Entered and left on a negedge.
  // The slave answers after the given wait counts; protocol rules and timing
  // are checked along the way, and the captured response is returned.
  task automatic run_txn(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                         input int a_dly, input int w_dly, input int r_dly, input int hold,
                         input logic [1:0] sresp, input logic [31:0] srdata,
                         output logic o_wr, output logic [1:0] o_resp, output logic [31:0] o_rdata);
    int cyc = 1, aw_cnt = 0, w_cnt = 0, ar_cnt = 0, aw_first = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_wait = 0, r_wait = 0, rsp_cyc = 0, held = 0;
    int aw_b = 0, w_b = 0, ar_b = 0, b_b = 0, r_b = 0;
    int rdy_bad = 0, proto_bad = 0, stable_bad = 0;
    logic aw_done = 0, w_done = 0, ar_done = 0, b_done = 0, r_done = 0, done = 0;
    logic aw_now, w_now, ar_now;
    logic [4:0]  cap_addr = 0;
    logic [31:0] cap_data = 0;
    o_wr = 0; o_resp = 0; o_rdata = 0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_addr = 5'($urandom); req_wdata = $urandom;  // must be registered
    while (!done && cyc < 200) begin
      if (req_ready) rdy_bad++;
      if (awvalid) begin
        aw_cnt++; if (aw_first == 0) aw_first = cyc;
        if (awaddr !== addr || awprot !== 3'b000) proto_bad++;
      end
      if (wvalid) begin
        w_cnt++;
        if (wdata !== wd || wstrb !== 4'hF) proto_bad++;
      end
      if (arvalid) begin
        ar_cnt++;
        if (araddr !== addr || arprot !== 3'b000) proto_bad++;
      end
      if (bready && (!wr || !(aw_done && w_done))) proto_bad++;
      if (rready && (wr || !ar_done || r_done)) proto_bad++;
      awready = awvalid && (aw_cnt > a_dly);
      wready  = wvalid  && (w_cnt  > w_dly);
      arready = arvalid && (ar_cnt > a_dly);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      ar_now = arvalid && arready;
      if (aw_now) begin aw_b++; aw_hs = cyc; cap_addr = awaddr; end
      if (w_now)  begin w_b++;  w_hs  = cyc; cap_data = wdata;  end
      if (ar_now) begin ar_b++; ar_hs = cyc; end
      bvalid = 0; rvalid = 0;
      if (aw_done && w_done && !b_done) begin
        bvalid = (b_wait >= r_dly); bresp = sresp; b_wait++;
        if (bvalid && bready) begin b_b++; b_done = 1; end
      end
      if (ar_done && !r_done) begin
        rvalid = (r_wait >= r_dly); rresp = sresp; rdata = srdata; r_wait++;
        if (rvalid && rready) begin r_b++; r_done = 1; end
      end
      if (aw_now) aw_done = 1;
      if (w_now)  w_done  = 1;
      if (ar_now) ar_done = 1;
      if (rsp_valid) begin
        if (rsp_cyc == 0) begin
          rsp_cyc = cyc; o_wr = rsp_write; o_resp = rsp_resp; o_rdata = rsp_rdata;
        end else if (rsp_write !== o_wr || rsp_resp !== o_resp || rsp_rdata !== o_rdata) begin
          stable_bad++;
        end
        rsp_ready = (held >= hold);
        held++;
        if (rsp_ready) done = 1;
      end else begin
        rsp_ready = 0;
      end
      @(negedge clk);
      cyc++;
    end
    slave_idle();
    chk("txn_completed", done, 1);
    chk("req_ready_low_while_busy", rdy_bad, 0);
    chk("axi_payload_prot_rules", proto_bad, 0);
    chk("rsp_stable_while_held", stable_bad, 0);
    if (wr) begin
      chk("aw_beats", aw_b, 1);
      chk("w_beats", w_b, 1);
      chk("b_beats", b_b, 1);
      chk("ar_beats_on_write", ar_b, 0);
      chk("awvalid_first_cycle", aw_first, 1);
      chk("awvalid_held_cycles", aw_cnt, a_dly + 1);
      chk("wvalid_held_cycles", w_cnt, w_dly + 1);
      chk("write_rsp_latency", rsp_cyc, ((aw_hs > w_hs) ? aw_hs : w_hs) + 2 + r_dly);
      if (aw_b == 1 && w_b == 1) smem[cap_addr] = cap_data;
    end else begin
      chk("ar_beats", ar_b, 1);
      chk("r_beats", r_b, 1);
      chk("aw_w_beats_on_read", aw_b + w_b, 0);
      chk("arvalid_held_cycles", ar_cnt, a_dly + 1);
      chk("read_rsp_latency", rsp_cyc, ar_hs + 2 + r_dly);
    end
    chk("rsp_valid_dropped", rsp_valid, 0);
    chk("req_ready_after_consume", req_ready, 1);
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          a_dly, w_dly, r_dly, hold;
    logic [1:0]  sresp;
    logic [31:0] srdata;
    logic        exp_wr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic        g_wr;
    logic [1:0]  g_resp;
    logic [31:0] g_rdata;
    int          split;

    vecs[0] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 0, 0, 0, 0, 2'b00, 32'h0,         1'b1, 2'b00, 32'h0};
    vecs[1] = '{1'b1, 5'd2,  32'h0000_07AA, 3, 0, 0, 0, 2'b00, 32'h0,         1'b1, 2'b00, 32'h0};
    vecs[2] = '{1'b0, 5'd3,  32'h0,         0, 0, 4, 0, 2'b00, 32'h0000_0001, 1'b0, 2'b00, 32'h0000_0001};
    vecs[3] = '{1'b0, 5'd7,  32'h0,         1, 0, 0, 0, 2'b10, 32'hDEAD_BEEF, 1'b0, 2'b10, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 5'd31, 32'h1234_5678, 1, 2, 2, 5, 2'b11, 32'h0,         1'b1, 2'b11, 32'h0};
    vecs[5] = '{1'b0, 5'd9,  32'h0,         0, 0, 0, 5, 2'b00, 32'hA5A5_A5A5, 1'b0, 2'b00, 32'hA5A5_A5A5};
    for (int i = 0; i < 32; i++) smem[i] = 32'h0;

    rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    slave_idle();
    repeat (3) @(negedge clk);
    chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
    chk("reset_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
    chk("reset_addr_data_strb", {awaddr, araddr, wdata, wstrb}, 46'h0);
    rst = 0;
    chk("req_ready_after_reset", req_ready, 1);

    // directed table
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].a_dly, vecs[i].w_dly,
              vecs[i].r_dly, vecs[i].hold, vecs[i].sresp, vecs[i].srdata, g_wr, g_resp, g_rdata);
      chk($sformatf("vec%0d_rsp_write", i), g_wr, vecs[i].exp_wr);
      chk($sformatf("vec%0d_rsp_resp", i), g_resp, vecs[i].exp_resp);
      chk($sformatf("vec%0d_rsp_rdata", i), g_rdata, vecs[i].exp_rdata);
    end
    chk("vec0_bus_write_landed", smem[0], 32'hFFFF_FFFF);
    chk("vec1_bus_write_landed", smem[2], 32'h0000_07AA);

    // reset while AWVALID is pending and the slave never answers
    req_valid = 1; req_write = 1; req_addr = 5'd5; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    req_valid = 0;
    chk("abort_awvalid_before_reset", {awvalid, wvalid}, 2'b11);
    rst = 1;
    @(negedge clk);
    chk("abort_valids_cleared", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    chk("abort_no_response", rsp_valid, 0);
    chk("abort_addr_data_strb", {awaddr, wdata, wstrb}, 41'h0);
    @(negedge clk);
    rst = 0;
    chk("abort_req_ready_after_release", req_ready, 1);
    split = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || awvalid || wvalid || !req_ready) split++;
    end
    chk("abort_quiet_after_release", split, 0);

    // randomized traffic against the reference register file
    for (int i = 0; i < 32; i++) refm[i] = smem[i];
    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [4:0]  a;
      logic [31:0] d;
      logic [1:0]  rs;
      wr = 1'($urandom);
      a  = 5'($urandom);
      d  = $urandom;
      rs = 2'($urandom);
      run_txn(wr, a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), rs, smem[a], g_wr, g_resp, g_rdata);
      chk("rand_rsp_write", g_wr, wr);
      chk("rand_rsp_resp", g_resp, rs);
      chk("rand_rsp_rdata", g_rdata, wr ? 32'h0 : refm[a]);
      if (wr) refm[a] = d;
    end
    for (int i = 0; i < 32; i++) chk($sformatf("rand_regfile_%0d", i), smem[i], refm[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
